// File: rtl/emif_initiator.sv
// EMIF bus initiator: turns a 1-4 byte-lane host command into EMIF byte cycles,
// with per-phase ack timeouts and a 2-flop synchroniser for the responder irq.
module emif_initiator #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int SETUP_CYCLES   = 1
) (
  input  logic        clk_app_i,
  input  logic        rst_clk_app_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_wr_i,
  input  logic [22:0] cmd_addr_i,
  input  logic [3:0]  cmd_be_i,
  input  logic [31:0] cmd_wdata_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic [22:0] memaddr,
  output logic [7:0]  memdatao,
  output logic        memrd,
  output logic        memwr,
  input  logic        memack,
  input  logic [7:0]  memdatai,
  input  logic        irq,
  output logic        irq_o,
  output logic        irq_rise_o
);
  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_STROBE, S_RELEASE, S_NEXT, S_RESP} state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0] SU_LAST = 16'(SETUP_CYCLES - 1);

  state_t      r_state;
  logic        r_wr;
  logic [22:0] r_addr;
  logic [3:0]  r_be;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic [1:0]  r_lane;
  logic [15:0] r_cnt;
  logic        r_irq_s1;
  logic        r_irq_d;

  logic [1:0]  w_first_lane;
  logic [1:0]  w_next_lane;
  logic        w_has_next;

  function automatic logic [7:0] lane_byte(input logic [31:0] w, input logic [1:0] l);
    return w[{l, 3'b000} +: 8];
  endfunction

  // Descending scan so the lowest qualifying lane wins.
  always_comb begin
    w_first_lane = '0;
    w_next_lane  = '0;
    w_has_next   = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if (cmd_be_i[i]) w_first_lane = 2'(i);
      if (r_be[i] && (i > int'(r_lane))) begin
        w_next_lane = 2'(i);
        w_has_next  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_app_i) begin
    if (rst_clk_app_i) begin
      r_state     <= S_IDLE;
      cmd_ready_o <= 1'b1;
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
      memaddr     <= '0;
      memdatao    <= '0;
      memrd       <= 1'b0;
      memwr       <= 1'b0;
      r_wr        <= 1'b0;
      r_addr      <= '0;
      r_be        <= '0;
      r_wdata     <= '0;
      r_rdata     <= '0;
      r_lane      <= '0;
      r_cnt       <= '0;
    end else begin
      rsp_valid_o <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cmd_valid_i && cmd_ready_o) begin
            cmd_ready_o <= 1'b0;
            r_wr        <= cmd_wr_i;
            r_addr      <= cmd_addr_i;
            r_be        <= cmd_be_i;
            r_wdata     <= cmd_wdata_i;
            r_rdata     <= '0;
            r_lane      <= w_first_lane;
            r_cnt       <= '0;
            if (cmd_be_i == 4'b0000) begin
              r_state     <= S_RESP;
              rsp_valid_o <= 1'b1;
              rsp_rdata_o <= '0;
              rsp_err_o   <= 1'b0;
            end else begin
              r_state  <= S_SETUP;
              memaddr  <= cmd_addr_i + 23'(w_first_lane);
              memdatao <= cmd_wr_i ? lane_byte(cmd_wdata_i, w_first_lane) : 8'h00;
            end
          end
        end
        S_SETUP: begin
          if (r_cnt == SU_LAST) begin
            r_state <= S_STROBE;
            r_cnt   <= '0;
            memrd   <= ~r_wr;
            memwr   <= r_wr;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        S_STROBE: begin
          if (memack) begin
            memrd   <= 1'b0;
            memwr   <= 1'b0;
            r_cnt   <= '0;
            r_state <= S_RELEASE;
            if (!r_wr) r_rdata[{r_lane, 3'b000} +: 8] <= memdatai;
          end else if (r_cnt == TO_LAST) begin
            // Abort: remaining lanes are skipped, partial rdata is reported.
            memrd       <= 1'b0;
            memwr       <= 1'b0;
            r_state     <= S_RESP;
            rsp_valid_o <= 1'b1;
            rsp_rdata_o <= r_rdata;
            rsp_err_o   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        S_RELEASE: begin
          if (!memack) begin
            r_state <= S_NEXT;
          end else if (r_cnt == TO_LAST) begin
            r_state     <= S_RESP;
            rsp_valid_o <= 1'b1;
            rsp_rdata_o <= r_rdata;
            rsp_err_o   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        S_NEXT: begin
          if (w_has_next) begin
            r_lane   <= w_next_lane;
            r_cnt    <= '0;
            r_state  <= S_SETUP;
            memaddr  <= r_addr + 23'(w_next_lane);
            memdatao <= r_wr ? lane_byte(r_wdata, w_next_lane) : 8'h00;
          end else begin
            r_state     <= S_RESP;
            rsp_valid_o <= 1'b1;
            rsp_rdata_o <= r_rdata;
            rsp_err_o   <= 1'b0;
          end
        end
        S_RESP: begin
          r_state     <= S_IDLE;
          cmd_ready_o <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_app_i) begin
    if (rst_clk_app_i) begin
      r_irq_s1 <= 1'b0;
      irq_o    <= 1'b0;
      r_irq_d  <= 1'b0;
    end else begin
      r_irq_s1 <= irq;
      irq_o    <= r_irq_s1;
      r_irq_d  <= irq_o;
    end
  end

  assign irq_rise_o = irq_o & ~r_irq_d;

endmodule

// File: doc/emif_initiator.md
Name: emif_initiator

Overview:
- EMIF bus initiator in the application clock domain.
- Converts a simple host command (read/write of 1-4 byte lanes of a 32-bit word) into EMIF byte cycles: memaddr/memdatao/memrd/memwr/memack/memdatai.
- Drives the slave-side EMIF port of the Ethernet MAC top (or any EMIF responder) from fabric logic without an MCU.
- Also synchronises the responder's irq and reports bus timeouts.

Parameters:
TIMEOUT_CYCLES, 64, max cycles waited for memack rise or fall per byte cycle before abort; legal range 2..65535
SETUP_CYCLES, 1, cycles address/data are stable before the strobe asserts; legal range 1..15

Ports:
clk_app_i  input  1  application clock; all logic on rising edge
rst_clk_app_i  input  1  synchronous, active-high reset
cmd_valid_i  input  1  command present
cmd_ready_o  output  1  command accepted when valid&ready
cmd_wr_i  input  1  1=write, 0=read
cmd_addr_i  input  23  byte address of lane 0
cmd_be_i  input  4  lane enables, bit n = byte n
cmd_wdata_i  input  32  write data, lane n = bits [8n+7:8n]
rsp_valid_o  output  1  one-cycle completion pulse
rsp_rdata_o  output  32  read data, held until next rsp
rsp_err_o  output  1  timeout abort flag, qualified by rsp_valid_o
memaddr  output  23  EMIF address
memdatao  output  8  EMIF write data
memrd  output  1  EMIF read strobe
memwr  output  1  EMIF write strobe
memack  input  1  EMIF acknowledge from responder
memdatai  input  8  EMIF read data
irq  input  1  responder interrupt, asynchronous
irq_o  output  1  irq after 2-flop synchroniser
irq_rise_o  output  1  one-cycle pulse on synchronised rising edge

Behaviour:
- Reset values: all outputs 0, except cmd_ready_o=1; FSM=IDLE; synchroniser flops 0.
- Reset mid-cycle: strobes drop in the next cycle; no rsp is issued for the aborted command.
- All EMIF outputs are registered; memrd and memwr are never both 1.
- FSM states: IDLE, SETUP, STROBE, RELEASE, NEXT, RESP.
- IDLE:
  - cmd_ready_o=1.
  - On accept: latch wr/addr/be/wdata; clear rdata accumulator to 0; lane index = lowest set be bit.
  - be=0000 -> RESP directly, with no bus cycle.
  - Otherwise -> SETUP.
- SETUP:
  - memaddr = (addr + lane) mod 2^23; 23-bit wrap, so 0x7FFFFF+1 = 0x000000.
  - memdatao = wdata lane on writes, 0 on reads.
  - Strobes low. Stay SETUP_CYCLES cycles, then -> STROBE.
- STROBE:
  - memwr (write) or memrd (read) = 1.
  - Timeout counter increments each cycle.
  - memack=1 seen: on a read, capture memdatai into rdata lane; -> RELEASE with strobe 0 next cycle.
  - Counter reaches TIMEOUT_CYCLES without ack: strobe 0, set err, -> RESP (remaining lanes skipped).
- RELEASE:
  - Strobes 0; counter restarted.
  - Wait for memack=0; if memack is already 0 in the first cycle, leave after 1 cycle.
  - Timeout with memack stuck at 1: set err, -> RESP.
  - Otherwise -> NEXT.
- NEXT:
  - Advance to the next higher set be bit -> SETUP.
  - No set bit remains -> RESP.
  - Lanes with be=0 never generate a bus cycle; their rdata lanes read 0.
- RESP:
  - rsp_valid_o=1 for exactly one cycle; rsp_rdata_o/rsp_err_o are valid in that cycle and held afterwards.
  - -> IDLE; cmd_ready_o=1 next cycle.
- Latency, single lane, SETUP_CYCLES=1, ack in first STROBE cycle, ack low next cycle:
  - accept cycle T; SETUP T+1; STROBE T+2; RELEASE T+3; NEXT T+4; RESP (rsp_valid_o) T+5.
  - Each additional enabled lane adds 4 cycles.
- memack high outside STROBE/RELEASE is ignored; memdatai is sampled only in the ack cycle of a read.
- irq synchroniser:
  - irq_o = second flop.
  - irq_rise_o = irq_o & ~previous irq_o.
  - Independent of FSM; active during commands.

Test Plan:
- Write cmd addr=0x040010, be=1111, wdata=0xA1B2C3D4, responder acks after 3 cycles -> four memwr cycles at 0x040010..0x040013 with memdatao D4,C3,B2,A1; rsp_valid_o once, rsp_err_o=0.
- Read cmd be=0101, addr=0x000100, responder returns 0x5A@0x100 and 0x3C@0x102 -> exactly two memrd cycles; rsp_rdata_o=0x003C005A.
- Single-lane read, immediate ack -> rsp_valid_o exactly 5 cycles after accept; memrd high exactly 1 cycle.
- Responder never acks, TIMEOUT_CYCLES=8, be=0011 -> memrd high 8 cycles then low; lane 1 not attempted; rsp_err_o=1.
- Write addr=0x7FFFFE, be=1111 -> memaddr sequence 0x7FFFFE, 0x7FFFFF, 0x000000, 0x000001; separately be=0000 -> rsp in 2 cycles with no strobe activity.
- Assert rst_clk_app_i during STROBE -> strobes 0 next cycle, no rsp; irq 0->1 pulse of 5 cycles -> irq_o rises after 2 cycles, irq_rise_o high 1 cycle.
